vga_pic_sched: RTL

Frame-synchronous picture-source scheduler for the VGA picture path. It sits between several picture generators and the VGA driver's `rgb_data` input. It selects one 24-bit source per frame, in one of two modes:
- auto mode: cycles through the sources every `FRAMES_PER_PIC` frames;
- manual mode: shows the source chosen through a request/acknowledge port.

Source changes take effect only at the vertical-sync boundary, so no frame is ever torn.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_sync_edge.sv | 29 ++
 rtl/vga_pic_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA picture path.
//   RGB_W  : width of one pixel (8 bits each of R, G, B)
//   clog2  : ceiling log2, used to size select and counter fields
//   mode_e : picture scheduler mode (manual / auto)
package vga_pkg;

    localparam int RGB_W = 24;

    typedef enum logic [0:0] {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } mode_e;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers the vertical sync and flags the start of each sync pulse.
//   vga_clk    : pixel clock
//   rst        : asynchronous active-high reset
//   v_sync     : vertical sync from the VGA driver, active level VS_POL
//   frame_tick : one-cycle pulse in the first cycle v_sync is at its active level
module vga_sync_edge #(
    parameter logic VS_POL = 1'b0
) (
    input  logic vga_clk,
    input  logic rst,
    input  logic v_sync,
    output logic frame_tick
);

    logic vs_d;

    // Reset to the active level so a sync already asserted when reset
    // releases does not produce a spurious tick.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            vs_d <= VS_POL;
        end else begin
            vs_d <= v_sync;
        end
    end

    assign frame_tick = (v_sync == VS_POL) && (vs_d != VS_POL);

endmodule

// File: rtl/vga_pic_sched.sv
// Frame-synchronous picture-source scheduler. Picks one of N_SRC 24-bit
// pixel sources per frame, either cycling automatically every
// FRAMES_PER_PIC frames or holding a source chosen over a req/ack port.
// The selection only changes on a frame tick (start of vertical sync).
//   vga_clk, rst      : pixel clock, asynchronous active-high reset
//   v_sync            : vertical sync, active level VS_POL
//   auto_en           : 1 = auto cycling, 0 = manual (sampled at frame ticks)
//   sel_req, sel_val  : manual select request (level-held) and source index
//   sel_ack, sel_err  : one-cycle resolve pulse; err = index out of range
//   rgb_in            : flattened sources, source k at [24k+23:24k]
//   rgb_data          : selected pixel
//   cur_sel           : source currently displayed
//   frame_cnt         : frames shown of the current source in auto mode
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_MANUAL | cur_sel held; changes only through a resolved request
// ST_AUTO   | cur_sel advances every FRAMES_PER_PIC frame ticks
module vga_pic_sched
    import vga_pkg::*;
#(
    parameter int   N_SRC          = 4,
    parameter int   FRAMES_PER_PIC = 60,
    parameter logic VS_POL         = 1'b0,
    parameter int   SEL_W          = clog2(N_SRC),
    parameter int   FC_W           = (clog2(FRAMES_PER_PIC) > 0) ? clog2(FRAMES_PER_PIC) : 1
) (
    input  logic                   vga_clk,
    input  logic                   rst,
    input  logic                   v_sync,
    input  logic                   auto_en,
    input  logic                   sel_req,
    input  logic [SEL_W-1:0]       sel_val,
    output logic                   sel_ack,
    output logic                   sel_err,
    input  logic [RGB_W*N_SRC-1:0] rgb_in,
    output logic [RGB_W-1:0]       rgb_data,
    output logic [SEL_W-1:0]       cur_sel,
    output logic [FC_W-1:0]        frame_cnt
);

    localparam logic [SEL_W:0]   N_SRC_X  = (SEL_W + 1)'(N_SRC);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_SRC - 1);
    localparam logic [FC_W-1:0]  CNT_LAST = FC_W'(FRAMES_PER_PIC - 1);

    logic             frame_tick;
    logic             req_d;
    logic             pend;
    logic [SEL_W-1:0] nxt_sel;
    mode_e            mode;
    logic             req_edge;
    logic             req_valid;

    vga_sync_edge #(
        .VS_POL(VS_POL)
    ) u_sync_edge (
        .vga_clk   (vga_clk),
        .rst       (rst),
        .v_sync    (v_sync),
        .frame_tick(frame_tick)
    );

    assign req_edge  = sel_req && !req_d && !pend;
    assign req_valid = {1'b0, nxt_sel} < N_SRC_X;

    // req_d resets high so a request still held through reset is not
    // re-captured on release; the requester must drop and re-raise it.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            mode      <= ST_MANUAL;
            cur_sel   <= '0;
            frame_cnt <= '0;
            sel_ack   <= 1'b0;
            sel_err   <= 1'b0;
            pend      <= 1'b0;
            nxt_sel   <= '0;
            req_d     <= 1'b1;
        end else begin
            req_d   <= sel_req;
            sel_ack <= 1'b0;
            sel_err <= 1'b0;

            // Capture and resolve are mutually exclusive on pend, so the
            // two writes to pend below never collide.
            if (req_edge) begin
                pend    <= 1'b1;
                nxt_sel <= sel_val;
            end

            if (frame_tick) begin
                mode <= auto_en ? ST_AUTO : ST_MANUAL;

                if (pend) begin
                    pend    <= 1'b0;
                    sel_ack <= 1'b1;
                    if (req_valid) begin
                        cur_sel   <= nxt_sel;
                        frame_cnt <= '0;
                    end else begin
                        sel_err <= 1'b1;
                        if (mode == ST_AUTO && !auto_en) begin
                            frame_cnt <= '0;
                        end
                    end
                end else if (mode == ST_AUTO) begin
                    if (!auto_en) begin
                        frame_cnt <= '0;
                    end else if (frame_cnt == CNT_LAST) begin
                        frame_cnt <= '0;
                        cur_sel   <= (cur_sel == SEL_LAST) ? '0 : cur_sel + SEL_W'(1);
                    end else begin
                        frame_cnt <= frame_cnt + FC_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        rgb_data = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (cur_sel == SEL_W'(k)) begin
                rgb_data = rgb_in[k*RGB_W +: RGB_W];
            end
        end
    end

endmodule
